// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock ratio meter.
//   meas_state_t : measurement FSM state encoding
//   MIN_RATIO    : smallest clk/clk_in ratio that yields a result
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } meas_state_t;

    localparam int unsigned MIN_RATIO = 2;

endpackage : clk_meas_pkg

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level into clk and flags its rising edge.
// Ports:
//   clk, nrst_int : reference clock, async active-low reset
//   d_in          : asynchronous input level
//   level         : synchronized level (last synchronizer stage)
//   rise          : high for one cycle when level goes 0 -> 1 (same cycle as level)
module sync_edge_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic nrst_int,
    input  logic d_in,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              rise_q;
    logic              rise_d;

    // Rise is precomputed from the stage about to enter the last position,
    // so the registered flag lines up with the registered level.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        rise_d = sync_q[STAGES-2] & ~sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge nrst_int) begin
        if (!nrst_int) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = rise_q;

endmodule : sync_edge_det

// File: rtl/clk_ratio_meter.sv
// Measures how many clk cycles fit in one clk_in period (averaged over
// 2**NPER_LOG2 periods) and how many of those clk_in was high.
// Ports:
//   clk, nrst_int : reference clock, async active-low reset
//   clk_in        : clock under measurement, asynchronous to clk
//   start         : one-cycle request, honoured only while idle
//   busy          : measurement in progress
//   valid         : one-cycle pulse, ratio/high_cycles just updated
//   timeout       : one-cycle pulse, measurement aborted without result
//   ratio         : clk cycles per clk_in period (truncated average)
//   high_cycles   : clk cycles clk_in was high in the last measured period
module clk_ratio_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NPER_LOG2   = 0,
    parameter int unsigned TIMEOUT     = 2**20
) (
    input  logic             clk,
    input  logic             nrst_int,
    input  logic             clk_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] ratio,
    output logic [CNT_W-1:0] high_cycles
);

    localparam int unsigned TC_W = CNT_W + NPER_LOG2;
    localparam int unsigned NP_W = NPER_LOG2 + 1;
    localparam logic [NP_W-1:0]  NP_LAST     = NP_W'(2**NPER_LOG2);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic in_level;
    logic in_rise;

    meas_state_t      state_q, state_d;
    logic [CNT_W-1:0] pc_q, pc_d;
    logic [TC_W-1:0]  tc_q, tc_d;
    logic [CNT_W-1:0] hc_q, hc_d;
    logic [NP_W-1:0]  np_q, np_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] pc_inc;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .nrst_int (nrst_int),
        .d_in     (clk_in),
        .level    (in_level),
        .rise     (in_rise)
    );

    // Measurement FSM: IDLE -> ARM (wait first edge) -> MEAS (count periods).
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tc_d      = tc_q;
        hc_d      = hc_q;
        np_d      = np_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        ratio_d   = ratio_q;
        high_d    = high_q;
        pc_inc    = pc_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    busy_d  = 1'b1;
                    pc_d    = '0;
                    tc_d    = '0;
                    np_d    = '0;
                end
            end
            ARM: begin
                // The rise sample itself is high, so it opens the high count at 1.
                if (in_rise) begin
                    state_d = MEAS;
                    pc_d    = CNT_W'(1);
                    tc_d    = TC_W'(1);
                    hc_d    = CNT_W'(1);
                end else if (pc_inc == TIMEOUT_CNT) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    pc_d = pc_inc;
                end
            end
            MEAS: begin
                if (in_rise) begin
                    pc_d = CNT_W'(1);
                    tc_d = tc_q + TC_W'(1);
                    hc_d = CNT_W'(1);
                    if (np_q + NP_W'(1) == NP_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                        ratio_d = CNT_W'(tc_q >> NPER_LOG2);
                        high_d  = hc_q;
                    end else begin
                        np_d = np_q + NP_W'(1);
                    end
                end else if (pc_inc == TIMEOUT_CNT) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    pc_d = pc_inc;
                    tc_d = tc_q + TC_W'(1);
                    hc_d = hc_q + CNT_W'(in_level);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst_int) begin
        if (!nrst_int) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            tc_q      <= '0;
            hc_q      <= '0;
            np_q      <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ratio_q   <= '0;
            high_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tc_q      <= tc_d;
            hc_q      <= hc_d;
            np_q      <= np_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ratio_q   <= ratio_d;
            high_q    <= high_d;
        end
    end

    assign busy        = busy_q;
    assign valid       = valid_q;
    assign timeout     = timeout_q;
    assign ratio       = ratio_q;
    assign high_cycles = high_q;

endmodule : clk_ratio_meter

// File: tb/tb_clk_ratio_meter.sv
// Bench for clk_ratio_meter: two instances (single-period and 4-period
// averaging) fed from a bench-side clock divider that changes on negedge clk.
module tb_clk_ratio_meter;

    localparam int S   = 2;
    localparam int TO0 = 64;
    localparam int TO1 = 2048;
    localparam int NL0 = 0;
    localparam int NL1 = 2;

    logic        clk      = 1'b0;
    logic        nrst_int = 1'b0;
    logic        clk_in   = 1'b0;
    logic        start    [2];
    logic        busy     [2];
    logic        valid    [2];
    logic        timeout  [2];
    logic [31:0] ratio    [2];
    logic [31:0] high_cycles [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // clk_in generator: divider (mode 1) or constant level (mode 0)
    int   gen_mode = 0;
    int   gen_div  = 2;
    int   gen_hi   = 1;
    int   gen_base = 0;
    logic gen_lvl  = 1'b0;

    // model state per instance (edge numbers, -1 = none)
    int          m_s   [2];
    int          m_end [2];
    int          m_v   [2];
    int          m_t   [2];
    logic [31:0] m_old_r [2];
    logic [31:0] m_new_r [2];
    logic [31:0] m_old_h [2];
    logic [31:0] m_new_h [2];

    // monitor counts per instance
    int n_valid [2];
    int n_to    [2];
    int t_cyc   [2];

    logic        e_busy, e_valid, e_to, e_done;
    logic [31:0] e_r, e_h;

    clk_ratio_meter #(
        .CNT_W(32), .SYNC_STAGES(S), .NPER_LOG2(NL0), .TIMEOUT(TO0)
    ) u_dut0 (
        .clk(clk), .nrst_int(nrst_int), .clk_in(clk_in), .start(start[0]),
        .busy(busy[0]), .valid(valid[0]), .timeout(timeout[0]),
        .ratio(ratio[0]), .high_cycles(high_cycles[0])
    );

    clk_ratio_meter #(
        .CNT_W(32), .SYNC_STAGES(S), .NPER_LOG2(NL1), .TIMEOUT(TO1)
    ) u_dut1 (
        .clk(clk), .nrst_int(nrst_int), .clk_in(clk_in), .start(start[1]),
        .busy(busy[1]), .valid(valid[1]), .timeout(timeout[1]),
        .ratio(ratio[1]), .high_cycles(high_cycles[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // value sampled at the coming edge number cyc+1
    always @(negedge clk) begin
        if (gen_mode == 1) clk_in <= (((cyc + 1 - gen_base) % gen_div) < gen_hi);
        else               clk_in <= gen_lvl;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        #1;
        if (nrst_int) begin
            for (int i = 0; i < 2; i++) begin
                e_busy  = (m_s[i] >= 0) && (cyc >= m_s[i]) && (cyc < m_end[i]);
                e_valid = (m_v[i] >= 0) && (cyc == m_v[i]);
                e_to    = (m_t[i] >= 0) && (cyc == m_t[i]);
                e_done  = (m_v[i] >= 0) && (cyc >= m_v[i]);
                e_r     = e_done ? m_new_r[i] : m_old_r[i];
                e_h     = e_done ? m_new_h[i] : m_old_h[i];
                chk($sformatf("busy%0d_c%0d", i, cyc), 32'(busy[i]), 32'(e_busy));
                chk($sformatf("valid%0d_c%0d", i, cyc), 32'(valid[i]), 32'(e_valid));
                chk($sformatf("timeout%0d_c%0d", i, cyc), 32'(timeout[i]), 32'(e_to));
                chk($sformatf("ratio%0d_c%0d", i, cyc), ratio[i], e_r);
                chk($sformatf("high%0d_c%0d", i, cyc), high_cycles[i], e_h);
                if (valid[i] === 1'b1) n_valid[i]++;
                if (timeout[i] === 1'b1) begin
                    n_to[i]++;
                    t_cyc[i] = cyc;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic set_div(input int div);
        gen_mode = 1;
        gen_div  = div;
        gen_hi   = (div + 1) / 2;
        gen_base = cyc + 1;
        tick(8);
    endtask

    task automatic set_const(input logic lvl);
        gen_mode = 0;
        gen_lvl  = lvl;
        tick(8);
    endtask

    // Raise start for one cycle and predict the outcome from the generator setup.
    task automatic do_start(input int i);
        int s, lo, nl, to, e1;
        nl = (i == 0) ? NL0 : NL1;
        to = (i == 0) ? TO0 : TO1;
        if (m_v[i] >= 0) begin
            m_old_r[i] = m_new_r[i];
            m_old_h[i] = m_new_h[i];
        end
        m_new_r[i] = m_old_r[i];
        m_new_h[i] = m_old_h[i];
        n_valid[i] = 0;
        n_to[i]    = 0;
        t_cyc[i]   = -1;
        s = cyc + 1;
        m_s[i] = s;
        if (gen_mode == 1 && gen_div >= 2 && gen_div < to) begin
            lo = s + 1 - S;
            e1 = gen_base + ((lo - gen_base + gen_div - 1) / gen_div) * gen_div;
            m_v[i]     = e1 + (1 << nl) * gen_div + S;
            m_t[i]     = -1;
            m_end[i]   = m_v[i];
            m_new_r[i] = 32'(gen_div);
            m_new_h[i] = 32'(gen_hi);
        end else begin
            m_v[i]   = -1;
            m_t[i]   = s + to;
            m_end[i] = m_t[i];
        end
        start[i] = 1'b1;
        tick(1);
        start[i] = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s[i] = -1; m_end[i] = -1; m_v[i] = -1; m_t[i] = -1;
            m_old_r[i] = '0; m_new_r[i] = '0;
            m_old_h[i] = '0; m_new_h[i] = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        start[0] = 1'b0;
        start[1] = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            n_valid[i] = 0; n_to[i] = 0; t_cyc[i] = -1;
        end

        // reset state
        tick(3);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
            chk($sformatf("rst_valid%0d", i), 32'(valid[i]), 0);
            chk($sformatf("rst_timeout%0d", i), 32'(timeout[i]), 0);
            chk($sformatf("rst_ratio%0d", i), ratio[i], 0);
            chk($sformatf("rst_high%0d", i), high_cycles[i], 0);
        end
        nrst_int = 1'b1;
        tick(2);

        // div=3, single period
        set_div(3);
        do_start(0);
        wait_until(m_end[0] + 2);
        chk("div3_ratio", ratio[0], 3);
        chk("div3_high_in_1_2", 32'(high_cycles[0] == 1 || high_cycles[0] == 2), 1);
        chk("div3_high", high_cycles[0], 2);
        chk("div3_nvalid", 32'(n_valid[0]), 1);

        // div=2, minimum ratio
        set_div(2);
        do_start(0);
        wait_until(m_end[0] + 2);
        chk("div2_ratio", ratio[0], 2);
        chk("div2_high", high_cycles[0], 1);
        chk("div2_nvalid", 32'(n_valid[0]), 1);

        // div=1000 averaged over 4 periods
        set_div(1000);
        do_start(1);
        wait_until(m_end[1] + 2);
        chk("div1000_ratio", ratio[1], 1000);
        chk("div1000_high", high_cycles[1], 500);
        chk("div1000_nvalid", 32'(n_valid[1]), 1);

        // clk_in stuck low -> timeout 64 cycles after arming
        set_const(1'b0);
        do_start(0);
        s = m_s[0];
        wait_until(m_end[0] + 3);
        chk("stuck0_nto", 32'(n_to[0]), 1);
        chk("stuck0_to_delay", 32'(t_cyc[0] - s), 64);
        chk("stuck0_nvalid", 32'(n_valid[0]), 0);
        chk("stuck0_ratio", ratio[0], 2);

        // clk_in equal to clk -> constant samples -> timeout
        set_const(1'b1);
        do_start(0);
        wait_until(m_end[0] + 3);
        chk("div1_nto", 32'(n_to[0]), 1);
        chk("div1_busy", 32'(busy[0]), 0);
        chk("div1_ratio", ratio[0], 2);

        // start pulses while busy and on the valid cycle are ignored
        set_div(10);
        do_start(0);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            start[0] = 1'b1;
            tick(1);
            start[0] = 1'b0;
        end
        wait_until(m_v[0] - 1);
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(4);
        chk("div10_busy_after", 32'(busy[0]), 0);
        chk("div10_nvalid", 32'(n_valid[0]), 1);
        chk("div10_ratio", ratio[0], 10);
        chk("div10_high", high_cycles[0], 5);

        // async reset mid-measurement, then a fresh measurement
        set_div(1000);
        do_start(1);
        tick(300);
        @(posedge clk);
        #2;
        nrst_int = 1'b0;
        model_reset();
        #1;
        chk("midrst_busy1", 32'(busy[1]), 0);
        chk("midrst_ratio1", ratio[1], 0);
        chk("midrst_high1", high_cycles[1], 0);
        chk("midrst_ratio0", ratio[0], 0);
        chk("midrst_valid1", 32'(valid[1]), 0);
        tick(2);
        nrst_int = 1'b1;
        tick(8);
        do_start(1);
        wait_until(m_end[1] + 2);
        chk("postrst_ratio", ratio[1], 1000);
        chk("postrst_high", high_cycles[1], 500);
        chk("postrst_nvalid", 32'(n_valid[1]), 1);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_clk_ratio_meter
